spu_issue_scoreboard: RTL and testbench

- Issue scheduler and hazard scoreboard for the dual-pipe (even/odd) 128x128-bit register file.
- Accepts one candidate instruction per pipe per cycle and stalls on RAW, WAW and writeback-port hazards.
- Issues in program order: even slot first, then odd.
- Generates the delayed write address and write enable for each pipe's register-file write port (rt_*_addr_in, wr_en_*).

---
 rtl/spu_issue_scoreboard.sv | 235 +++++++++++++++++++++++
 tb/tb_spu_issue_scoreboard.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// spu_issue_scoreboard
//
// Issue scheduler and hazard scoreboard for the dual-pipe (even/odd)
// register file. Each cycle one candidate per pipe is offered. The block
// accepts or stalls each candidate on RAW, WAW and writeback-port hazards,
// and always issues in program order (even before odd). It also produces
// the delayed write address and enable for each pipe's register-file write
// port.
//
// Writeback timing: a writer issued in cycle T with latency L drives
// wb_*_en/wb_*_addr in cycle T+L. Its busy_vec bit is high from T+1 up to
// and including T+L-1, so a consumer may issue in the write cycle itself.
//
// Optional build macro: SCOREBOARD_STALL_CNT_EN adds the stall_cnt output,
// a saturating 32-bit count of cycles in which a valid candidate stalled.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ev_valid / od_valid        candidate present on even / odd pipe
//   *_ra, *_rb, *_rc           source register addresses
//   *_ra_use, *_rb_use, *_rc_use  source is actually read
//   *_rt, *_rt_use             destination register, instruction writes it
//   *_lat                      execution latency, legal 1..MAX_LAT
//   ev_issue / od_issue        candidate accepted this cycle (combinational)
//   wb_ev_en / wb_ev_addr      even write-port enable / address
//   wb_od_en / wb_od_addr      odd write-port enable / address
//   busy_vec                   per-register pending-write flags
//   stall_cnt                  (SCOREBOARD_STALL_CNT_EN only) stall cycles
// ---------------------------------------------------------------------------
module spu_issue_scoreboard #(
  parameter  int SIZE    = 128,
  parameter  int MAX_LAT = 7,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ev_valid,
  input  logic [LOGSIZE-1:0] ev_ra,
  input  logic [LOGSIZE-1:0] ev_rb,
  input  logic [LOGSIZE-1:0] ev_rc,
  input  logic               ev_ra_use,
  input  logic               ev_rb_use,
  input  logic               ev_rc_use,
  input  logic [LOGSIZE-1:0] ev_rt,
  input  logic               ev_rt_use,
  input  logic [2:0]         ev_lat,
  input  logic               od_valid,
  input  logic [LOGSIZE-1:0] od_ra,
  input  logic [LOGSIZE-1:0] od_rb,
  input  logic [LOGSIZE-1:0] od_rc,
  input  logic               od_ra_use,
  input  logic               od_rb_use,
  input  logic               od_rc_use,
  input  logic [LOGSIZE-1:0] od_rt,
  input  logic               od_rt_use,
  input  logic [2:0]         od_lat,
  output logic               ev_issue,
  output logic               od_issue,
  output logic               wb_ev_en,
  output logic [LOGSIZE-1:0] wb_ev_addr,
  output logic               wb_od_en,
  output logic [LOGSIZE-1:0] wb_od_addr,
  output logic [SIZE-1:0]    busy_vec
`ifdef SCOREBOARD_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  // Slot 0 of each writeback shift register is the output register pair
  // {wb_*_en, wb_*_addr}; slots 1..TOP live in the *_vld_q / *_addr_q arrays.
  localparam int TOP = MAX_LAT - 1;

  logic [TOP:1]       ev_vld_q, ev_vld_d;
  logic [TOP:1]       od_vld_q, od_vld_d;
  logic [LOGSIZE-1:0] ev_addr_q [1:TOP];
  logic [LOGSIZE-1:0] ev_addr_d [1:TOP];
  logic [LOGSIZE-1:0] od_addr_q [1:TOP];
  logic [LOGSIZE-1:0] od_addr_d [1:TOP];
  logic               ev_wb_en_d, od_wb_en_d;
  logic [LOGSIZE-1:0] ev_wb_addr_d, od_wb_addr_d;
  logic               ev_hazard, od_hazard, pair_dep;
  logic [SIZE-1:0]    busy_d;

  function automatic logic lat_bad(input logic [2:0] lat);
    return (lat == 3'd0) || (int'(lat) > MAX_LAT);
  endfunction

  // Slot lat-1 after this cycle's shift holds what slot lat holds now;
  // a latency of MAX_LAT targets the top slot, which is always empty after
  // the shift.
  function automatic logic port_taken(input logic [TOP:1] vld,
                                      input logic [2:0]   lat);
    logic taken;
    taken = 1'b0;
    for (int i = 1; i <= TOP; i++)
      if (int'(lat) == i) taken = vld[i];
    return taken;
  endfunction

  function automatic logic src_busy(input logic [SIZE-1:0]    busy,
                                    input logic [LOGSIZE-1:0] ra,
                                    input logic               ra_use,
                                    input logic [LOGSIZE-1:0] rb,
                                    input logic               rb_use,
                                    input logic [LOGSIZE-1:0] rc,
                                    input logic               rc_use);
    return (ra_use & busy[ra]) | (rb_use & busy[rb]) | (rc_use & busy[rc]);
  endfunction

  // ---- issue decision (combinational from candidates and scoreboard state)
  assign ev_hazard = lat_bad(ev_lat)
                   | src_busy(busy_vec, ev_ra, ev_ra_use, ev_rb, ev_rb_use,
                              ev_rc, ev_rc_use)
                   | (ev_rt_use & busy_vec[ev_rt])
                   | port_taken(ev_vld_q, ev_lat);

  // An odd instruction may not read or rewrite the register that the even
  // instruction issuing alongside it is about to write.
  assign pair_dep = ev_issue & ev_rt_use &
                    ((od_ra_use & (od_ra == ev_rt)) |
                     (od_rb_use & (od_rb == ev_rt)) |
                     (od_rc_use & (od_rc == ev_rt)) |
                     (od_rt_use & (od_rt == ev_rt)));

  assign od_hazard = lat_bad(od_lat)
                   | src_busy(busy_vec, od_ra, od_ra_use, od_rb, od_rb_use,
                              od_rc, od_rc_use)
                   | (od_rt_use & busy_vec[od_rt])
                   | port_taken(od_vld_q, od_lat)
                   | pair_dep;

  assign ev_issue = rst_n & ev_valid & ~ev_hazard;
  assign od_issue = rst_n & od_valid & ~od_hazard & (ev_issue | ~ev_valid);

  // ---- writeback slots: shift toward slot 0, insert new writer at lat-1
  always_comb begin
    ev_wb_en_d   = ev_vld_q[1];
    ev_wb_addr_d = ev_addr_q[1];
    ev_vld_d     = '0;
    ev_addr_d    = ev_addr_q;
    for (int i = 1; i < TOP; i++) begin
      ev_vld_d[i]  = ev_vld_q[i+1];
      ev_addr_d[i] = ev_addr_q[i+1];
    end
    if (ev_issue && ev_rt_use) begin
      if (ev_lat == 3'd1) begin
        ev_wb_en_d   = 1'b1;
        ev_wb_addr_d = ev_rt;
      end
      for (int i = 1; i <= TOP; i++) begin
        if (int'(ev_lat) == i + 1) begin
          ev_vld_d[i]  = 1'b1;
          ev_addr_d[i] = ev_rt;
        end
      end
    end
  end

  always_comb begin
    od_wb_en_d   = od_vld_q[1];
    od_wb_addr_d = od_addr_q[1];
    od_vld_d     = '0;
    od_addr_d    = od_addr_q;
    for (int i = 1; i < TOP; i++) begin
      od_vld_d[i]  = od_vld_q[i+1];
      od_addr_d[i] = od_addr_q[i+1];
    end
    if (od_issue && od_rt_use) begin
      if (od_lat == 3'd1) begin
        od_wb_en_d   = 1'b1;
        od_wb_addr_d = od_rt;
      end
      for (int i = 1; i <= TOP; i++) begin
        if (int'(od_lat) == i + 1) begin
          od_vld_d[i]  = 1'b1;
          od_addr_d[i] = od_rt;
        end
      end
    end
  end

  // Clear a register's busy bit as its write moves into slot 0, so the bit
  // is already low in the write cycle. A latency-1 writer never marks its
  // register busy: its write lands in the very next cycle. Sets are applied
  // after clears so a coincident set wins.
  always_comb begin
    busy_d = busy_vec;
    if (ev_vld_q[1]) busy_d[ev_addr_q[1]] = 1'b0;
    if (od_vld_q[1]) busy_d[od_addr_q[1]] = 1'b0;
    if (ev_issue && ev_rt_use && (ev_lat > 3'd1)) busy_d[ev_rt] = 1'b1;
    if (od_issue && od_rt_use && (od_lat > 3'd1)) busy_d[od_rt] = 1'b1;
  end

  // ---- state registers: control and output slot are reset, the upper
  // address slots are qualified by their valid bits and carry no reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_vld_q   <= '0;
      od_vld_q   <= '0;
      wb_ev_en   <= 1'b0;
      wb_od_en   <= 1'b0;
      wb_ev_addr <= '0;
      wb_od_addr <= '0;
      busy_vec   <= '0;
    end else begin
      ev_vld_q   <= ev_vld_d;
      od_vld_q   <= od_vld_d;
      wb_ev_en   <= ev_wb_en_d;
      wb_od_en   <= od_wb_en_d;
      wb_ev_addr <= ev_wb_addr_d;
      wb_od_addr <= od_wb_addr_d;
      busy_vec   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    ev_addr_q <= ev_addr_d;
    od_addr_q <= od_addr_d;
  end

`ifdef SCOREBOARD_STALL_CNT_EN
  // ---- stall counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (((ev_valid & ~ev_issue) | (od_valid & ~od_issue)) &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
`timescale 1ns/1ps
module tb_spu_issue_scoreboard;

  localparam int MAX_LAT = 7;

  typedef struct packed {
    logic       vld;
    logic [6:0] ra, rb, rc;
    logic       ra_u, rb_u, rc_u;
    logic [6:0] rt;
    logic       rt_u;
    logic [2:0] lat;
  } cand_t;

  typedef struct packed {
    cand_t ev;
    cand_t od;
    logic  exp_ev;
    logic  exp_od;
  } vec_t;

  typedef struct {
    int pipe;
    int addr;
    int due;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  cand_t        ev_c = '0;
  cand_t        od_c = '0;
  logic         ev_issue, od_issue, wb_ev_en, wb_od_en;
  logic [6:0]   wb_ev_addr, wb_od_addr;
  logic [127:0] busy_vec;
`ifdef SCOREBOARD_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  spu_issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_c.vld), .ev_ra(ev_c.ra), .ev_rb(ev_c.rb), .ev_rc(ev_c.rc),
    .ev_ra_use(ev_c.ra_u), .ev_rb_use(ev_c.rb_u), .ev_rc_use(ev_c.rc_u),
    .ev_rt(ev_c.rt), .ev_rt_use(ev_c.rt_u), .ev_lat(ev_c.lat),
    .od_valid(od_c.vld), .od_ra(od_c.ra), .od_rb(od_c.rb), .od_rc(od_c.rc),
    .od_ra_use(od_c.ra_u), .od_rb_use(od_c.rb_u), .od_rc_use(od_c.rc_u),
    .od_rt(od_c.rt), .od_rt_use(od_c.rt_u), .od_lat(od_c.lat),
    .ev_issue(ev_issue), .od_issue(od_issue),
    .wb_ev_en(wb_ev_en), .wb_ev_addr(wb_ev_addr),
    .wb_od_en(wb_od_en), .wb_od_addr(wb_od_addr),
    .busy_vec(busy_vec)
`ifdef SCOREBOARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_illegal = 0;
  int cyc = 0;
  wr_t fly[$];

  // samples taken mid-cycle by run_cycle
  logic         s_ev, s_od, s_wbe, s_wbo;
  logic [6:0]   s_wbe_a, s_wbo_a;
  logic [127:0] s_busy;
  bit           m_ev, m_od;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Illegal latency on a presented candidate is flagged, not fatal: the
  // bench deliberately presents a few to check they are refused.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(ev_c.vld && (ev_c.lat == 3'd0 || int'(ev_c.lat) > MAX_LAT)))
      else begin
        n_illegal++;
        $display("[TB] note: illegal even latency %0d presented", ev_c.lat);
      end
      assert (!(od_c.vld && (od_c.lat == 3'd0 || int'(od_c.lat) > MAX_LAT)))
      else begin
        n_illegal++;
        $display("[TB] note: illegal odd latency %0d presented", od_c.lat);
      end
    end
  end

  // ---------------- reference model: list of pending writes ----------------
  function automatic bit m_busy(input int r);
    foreach (fly[i]) if (fly[i].addr == r && fly[i].due > cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_port(input int p, input int lat);
    foreach (fly[i]) if (fly[i].pipe == p && fly[i].due == cyc + lat) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard(input cand_t c, input int p);
    if (c.lat == 3'd0 || int'(c.lat) > MAX_LAT) return 1'b1;
    if (c.ra_u && m_busy(int'(c.ra))) return 1'b1;
    if (c.rb_u && m_busy(int'(c.rb))) return 1'b1;
    if (c.rc_u && m_busy(int'(c.rc))) return 1'b1;
    if (c.rt_u && m_busy(int'(c.rt))) return 1'b1;
    return m_port(p, int'(c.lat));
  endfunction

  task automatic run_cycle();
    bit           pair, e_wbe, e_wbo;
    int           e_wbe_a, e_wbo_a;
    logic [127:0] e_busy;
    @(negedge clk);
    if (!rst_n) fly.delete();
    m_ev = rst_n && ev_c.vld && !m_hazard(ev_c, 0);
    pair = m_ev && ev_c.rt_u &&
           ((od_c.ra_u && od_c.ra == ev_c.rt) || (od_c.rb_u && od_c.rb == ev_c.rt) ||
            (od_c.rc_u && od_c.rc == ev_c.rt) || (od_c.rt_u && od_c.rt == ev_c.rt));
    m_od = rst_n && od_c.vld && !m_hazard(od_c, 1) && !pair && (m_ev || !ev_c.vld);
    e_busy = '0; e_wbe = 0; e_wbo = 0; e_wbe_a = 0; e_wbo_a = 0;
    foreach (fly[i]) begin
      if (fly[i].due > cyc) e_busy[fly[i].addr] = 1'b1;
      if (fly[i].due == cyc && fly[i].pipe == 0) begin e_wbe = 1; e_wbe_a = fly[i].addr; end
      if (fly[i].due == cyc && fly[i].pipe == 1) begin e_wbo = 1; e_wbo_a = fly[i].addr; end
    end
    s_ev = ev_issue; s_od = od_issue; s_wbe = wb_ev_en; s_wbo = wb_od_en;
    s_wbe_a = wb_ev_addr; s_wbo_a = wb_od_addr; s_busy = busy_vec;
    chk("model_ev_issue", 128'(s_ev), 128'(m_ev));
    chk("model_od_issue", 128'(s_od), 128'(m_od));
    chk("model_wb_ev_en", 128'(s_wbe), 128'(e_wbe));
    chk("model_wb_od_en", 128'(s_wbo), 128'(e_wbo));
    if (e_wbe) chk("model_wb_ev_addr", 128'(s_wbe_a), 128'(e_wbe_a));
    if (e_wbo) chk("model_wb_od_addr", 128'(s_wbo_a), 128'(e_wbo_a));
    chk("model_busy_vec", s_busy, e_busy);
    if (m_ev && ev_c.rt_u) fly.push_back('{0, int'(ev_c.rt), cyc + int'(ev_c.lat)});
    if (m_od && od_c.rt_u) fly.push_back('{1, int'(od_c.rt), cyc + int'(od_c.lat)});
    @(posedge clk);
    #1;
    cyc++;
    for (int i = fly.size() - 1; i >= 0; i--) if (fly[i].due < cyc) fly.delete(i);
  endtask

  task automatic idle(input int n);
    ev_c = '0; od_c = '0;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // use_abc: bit2 = ra used, bit1 = rb used, bit0 = rc used
  function automatic cand_t mk(input int ra, input int rb, input int rc, input bit [2:0] use_abc,
                               input int rt, input bit wr, input int lat);
    cand_t c;
    c.vld = 1'b1;
    c.ra = 7'(ra); c.rb = 7'(rb); c.rc = 7'(rc);
    c.ra_u = use_abc[2]; c.rb_u = use_abc[1]; c.rc_u = use_abc[0];
    c.rt = 7'(rt); c.rt_u = wr; c.lat = 3'(lat);
    return c;
  endfunction

  function automatic cand_t rnd_cand();
    cand_t c;
    c.vld  = ($urandom_range(9) < 7);
    c.ra   = 7'($urandom_range(15));
    c.rb   = 7'($urandom_range(15));
    c.rc   = 7'($urandom_range(15));
    c.ra_u = 1'($urandom_range(1));
    c.rb_u = 1'($urandom_range(1));
    c.rc_u = 1'($urandom_range(1));
    c.rt   = 7'($urandom_range(15));
    c.rt_u = ($urandom_range(3) != 0);
    c.lat  = 3'($urandom_range(MAX_LAT, 1));
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t  vt[12];
    cand_t c;
    bit    seen;
    logic [127:0] busy_or;
    bit    ev_took, od_took;

    // ---- reset state
    rst_n = 1'b0;
    ev_c = mk(0, 0, 0, 3'b000, 5, 1, 3);
    run_cycle();
    chk("reset_ev_issue", 128'(s_ev), 128'(0));
    chk("reset_busy_vec", s_busy, 128'(0));
    chk("reset_wb_ev_en", 128'(s_wbe), 128'(0));
    chk("reset_wb_ev_addr", 128'(s_wbe_a), 128'(0));
    rst_n = 1'b1;

    // ---- first writer after reset: rt=5 lat=3 writes 3 cycles later
    run_cycle();
    chk("first_issue", 128'(s_ev), 128'(1));
    ev_c = '0;
    run_cycle();
    chk("first_busy5", 128'(s_busy[5]), 128'(1));
    run_cycle();
    chk("first_wb_early", 128'(s_wbe), 128'(0));
    run_cycle();
    chk("first_wb_en", 128'(s_wbe), 128'(1));
    chk("first_wb_addr", 128'(s_wbe_a), 128'(5));
    chk("first_busy5_clr", 128'(s_busy[5]), 128'(0));
    idle(MAX_LAT + 1);

    // ---- table of single-cycle issue decisions from an idle scoreboard
    vt[0]  = '{mk(1, 2, 3, 3'b000, 5, 1, 3), '0, 1'b1, 1'b0};
    vt[1]  = '{'0, mk(1, 2, 3, 3'b000, 6, 1, 2), 1'b0, 1'b1};
    vt[2]  = '{mk(1, 2, 3, 3'b000, 0, 0, 0), mk(4, 5, 6, 3'b111, 7, 1, 1), 1'b0, 1'b0};
    vt[3]  = '{mk(0, 0, 0, 3'b000, 20, 1, 2), mk(20, 0, 0, 3'b100, 0, 0, 1), 1'b1, 1'b0};
    vt[4]  = '{mk(0, 0, 0, 3'b000, 20, 1, 2), mk(20, 21, 0, 3'b010, 0, 0, 1), 1'b1, 1'b1};
    vt[5]  = '{mk(0, 0, 0, 3'b000, 20, 1, 2), mk(0, 0, 0, 3'b000, 20, 1, 4), 1'b1, 1'b0};
    vt[6]  = '{mk(0, 0, 0, 3'b000, 20, 0, 2), mk(20, 0, 0, 3'b100, 0, 0, 1), 1'b1, 1'b1};
    vt[7]  = '{mk(1, 2, 3, 3'b111, 11, 1, 1), mk(1, 2, 3, 3'b111, 12, 1, 0), 1'b1, 1'b0};
    vt[8]  = '{mk(0, 0, 0, 3'b000, 9, 1, 7), mk(0, 0, 9, 3'b001, 13, 1, 3), 1'b1, 1'b0};
    vt[9]  = '{mk(0, 0, 0, 3'b000, 0, 1, 1), mk(0, 0, 0, 3'b010, 14, 1, 2), 1'b1, 1'b0};
    vt[10] = '{mk(3, 0, 0, 3'b100, 3, 1, 7), mk(0, 0, 0, 3'b000, 4, 1, 7), 1'b1, 1'b1};
    c = mk(0, 0, 0, 3'b000, 8, 1, 2);
    c.vld = 1'b0;
    vt[11] = '{c, mk(8, 0, 0, 3'b100, 0, 0, 1), 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      ev_c = vt[i].ev; od_c = vt[i].od;
      run_cycle();
      chk($sformatf("vec%0d_ev_issue", i), 128'(s_ev), 128'(vt[i].exp_ev));
      chk($sformatf("vec%0d_od_issue", i), 128'(s_od), 128'(vt[i].exp_od));
      idle(MAX_LAT + 1);
    end

    // ---- RAW stall: consumer of r10 waits until the write cycle
    ev_c = mk(0, 0, 0, 3'b000, 10, 1, 4);
    run_cycle();
    chk("raw_producer", 128'(s_ev), 128'(1));
    ev_c = mk(10, 0, 0, 3'b100, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      run_cycle();
      chk($sformatf("raw_stall_t%0d", k), 128'(s_ev), 128'(0));
    end
    run_cycle();
    chk("raw_release_t4", 128'(s_ev), 128'(1));
    idle(MAX_LAT + 1);

    // ---- intra-pair dependency: odd reads what even writes
    ev_c = mk(0, 0, 0, 3'b000, 20, 1, 2);
    od_c = mk(20, 0, 0, 3'b100, 0, 0, 1);
    run_cycle();
    chk("pair_ev_issue", 128'(s_ev), 128'(1));
    chk("pair_od_stall", 128'(s_od), 128'(0));
    ev_c = '0;
    run_cycle();
    chk("pair_od_busy", 128'(s_od), 128'(0));
    run_cycle();
    chk("pair_od_release", 128'(s_od), 128'(1));
    idle(MAX_LAT + 1);

    // ---- port conflict on even pipe, odd held behind stalled even
    ev_c = mk(0, 0, 0, 3'b000, 30, 1, 3);
    run_cycle();
    chk("port_first", 128'(s_ev), 128'(1));
    ev_c = mk(0, 0, 0, 3'b000, 31, 1, 2);
    od_c = mk(0, 0, 0, 3'b000, 0, 0, 1);
    run_cycle();
    chk("port_ev_stall", 128'(s_ev), 128'(0));
    chk("port_od_inorder", 128'(s_od), 128'(0));
    run_cycle();
    chk("port_ev_retry", 128'(s_ev), 128'(1));
    chk("port_od_retry", 128'(s_od), 128'(1));
    ev_c = '0; od_c = '0;
    run_cycle();
    chk("port_wb_first", 128'(s_wbe_a), 128'(30));
    run_cycle();
    chk("port_wb_second", 128'(s_wbe_a), 128'(31));
    idle(MAX_LAT + 1);

    // ---- reset with three writes in flight
    ev_c = mk(0, 0, 0, 3'b000, 40, 1, 7);
    od_c = mk(0, 0, 0, 3'b000, 41, 1, 6);
    run_cycle();
    chk("midrst_issue_pair", 128'({s_ev, s_od}), 128'(2'b11));
    ev_c = mk(0, 0, 0, 3'b000, 42, 1, 5);
    od_c = '0;
    run_cycle();
    chk("midrst_busy_before", s_busy, (128'(1) << 40) | (128'(1) << 41));
    ev_c = '0;
    rst_n = 1'b0;
    run_cycle();
    chk("midrst_busy_in_reset", s_busy, 128'(0));
    rst_n = 1'b1;
    seen = 0; busy_or = '0;
    for (int k = 0; k < MAX_LAT + 2; k++) begin
      run_cycle();
      seen |= s_wbe | s_wbo;
      busy_or |= s_busy;
    end
    chk("midrst_no_wb", 128'(seen), 128'(0));
    chk("midrst_busy_after", busy_or, 128'(0));

`ifdef SCOREBOARD_STALL_CNT_EN
    // ---- stall counter: five stalled cycles, then saturation
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
    ev_c = mk(0, 0, 0, 3'b000, 0, 0, 0);
    for (int k = 0; k < 5; k++) run_cycle();
    ev_c = '0;
    run_cycle();
    chk("stall_cnt_five", 128'(stall_cnt), 128'(5));
    force dut.stall_cnt = 32'hFFFF_FFFD;
    run_cycle();
    release dut.stall_cnt;
    ev_c = mk(0, 0, 0, 3'b000, 0, 0, 0);
    for (int k = 0; k < 4; k++) run_cycle();
    ev_c = '0;
    run_cycle();
    chk("stall_cnt_saturate", 128'(stall_cnt), 128'(32'hFFFF_FFFF));
`endif

    // ---- randomized traffic, candidates held until accepted
    ev_took = 1; od_took = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!ev_c.vld || ev_took) ev_c = rnd_cand();
      if (!od_c.vld || od_took) od_c = rnd_cand();
      rst_n = ($urandom_range(399) != 0);
      run_cycle();
      ev_took = m_ev; od_took = m_od;
    end
    rst_n = 1'b1;
    idle(MAX_LAT + 1);

    $display("[TB] illegal-latency flags raised: %0d", n_illegal);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
